captura_jogada: RTL and testbench

CAPTURA_JOGADA -- requirements
Module: captura_jogada

---
 rtl/captura_jogada.sv | 174 +++++++++++++++++
 tb/tb_captura_jogada.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/captura_jogada.sv
// Move capture: debounced confirm/cancel buttons drive an FSM that latches {origem, destino}.
// Optional macro CAPTURA_VALIDA_EN enables rejection of moves with origem == destino.

module captura_jogada_db #(
   parameter int DEBOUNCE_N = 50000
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_i,
   output logic evt_o
);
   localparam int CW = $clog2(DEBOUNCE_N + 1);

   logic [1:0]    sync_q;
   logic          lvl_q, lvl_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] arm_cnt_q, arm_cnt_d;
   logic          armed_q, armed_d;
   logic          evt_q, evt_d;
   logic          s;

   assign s = sync_q[1];

   always_comb begin
      lvl_d = lvl_q;
      cnt_d = cnt_q;
      if (s == lvl_q)
         cnt_d = '0;
      else if (cnt_q == CW'(DEBOUNCE_N - 1)) begin
         lvl_d = s;
         cnt_d = '0;
      end else if (cnt_q != CW'(DEBOUNCE_N))
         cnt_d = cnt_q + CW'(1);
   end

   // A button held through reset must be seen released for DEBOUNCE_N cycles
   // before its presses count, so arming waits on a stable-low run.
   always_comb begin
      arm_cnt_d = '0;
      if (!s)
         arm_cnt_d = (arm_cnt_q == CW'(DEBOUNCE_N)) ? arm_cnt_q : arm_cnt_q + CW'(1);
      armed_d = armed_q | (arm_cnt_q == CW'(DEBOUNCE_N));
      evt_d   = lvl_d & ~lvl_q & armed_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q    <= '0;
         lvl_q     <= 1'b0;
         cnt_q     <= '0;
         arm_cnt_q <= '0;
         armed_q   <= 1'b0;
         evt_q     <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], raw_i};
         lvl_q     <= lvl_d;
         cnt_q     <= cnt_d;
         arm_cnt_q <= arm_cnt_d;
         armed_q   <= armed_d;
         evt_q     <= evt_d;
      end
   end

   assign evt_o = evt_q;
endmodule

module captura_jogada #(
   parameter int DEBOUNCE_N = 50000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [5:0]  casa,
   input  logic        confirma,
   input  logic        cancela,
   input  logic        zeraR,
   output logic [11:0] jogada,
   output logic        temJogada,
   output logic        erroJogada,
   output logic [3:0]  db_estado
);
   localparam int NUM_BTN = 2;

   typedef enum logic [3:0] {
      ESPERA_ORIGEM  = 4'h0,
      ESPERA_DESTINO = 4'h2,
      VALIDA         = 4'h4,
      PRONTA         = 4'h6,
      REJEITA        = 4'hE
   } estado_t;

   estado_t              state_q, state_d;
   logic [NUM_BTN-1:0]   btn_raw, btn_evt;
   logic [5:0]           origem_q, origem_d, destino_q, destino_d;
   logic                 tem_q, erro_q;
   logic                 conf_ev, canc_ev, aceita;

   assign btn_raw = {cancela, confirma};

   for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
      captura_jogada_db #(.DEBOUNCE_N(DEBOUNCE_N)) u_db (
         .clock (clock),
         .reset (reset),
         .raw_i (btn_raw[b]),
         .evt_o (btn_evt[b])
      );
   end

   assign conf_ev = btn_evt[0];
   assign canc_ev = btn_evt[1];

`ifdef CAPTURA_VALIDA_EN
   assign aceita = (origem_q != destino_q);
`else
   assign aceita = 1'b1;
`endif

   always_comb begin
      state_d   = state_q;
      origem_d  = origem_q;
      destino_d = destino_q;
      case (state_q)
         ESPERA_ORIGEM:
            if (conf_ev && !canc_ev) begin
               origem_d = casa;
               state_d  = ESPERA_DESTINO;
            end
         ESPERA_DESTINO:
            if (canc_ev)
               state_d = ESPERA_ORIGEM;
            else if (conf_ev) begin
               destino_d = casa;
               state_d   = VALIDA;
            end
         VALIDA:
            if (canc_ev)
               state_d = ESPERA_ORIGEM;
            else
               state_d = aceita ? PRONTA : REJEITA;
         PRONTA:
            if (zeraR)
               state_d = ESPERA_ORIGEM;
         REJEITA:
            state_d = ESPERA_ORIGEM;
         default:
            state_d = ESPERA_ORIGEM;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ESPERA_ORIGEM;
         origem_q  <= '0;
         destino_q <= '0;
         tem_q     <= 1'b0;
         erro_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         origem_q  <= origem_d;
         destino_q <= destino_d;
         tem_q     <= (state_d == PRONTA);
`ifdef CAPTURA_VALIDA_EN
         erro_q    <= (state_d == REJEITA);
`else
         erro_q    <= 1'b0;
`endif
      end
   end

   assign jogada     = {origem_q, destino_q};
   assign temJogada  = tem_q;
   assign erroJogada = erro_q;
   assign db_estado  = state_q;
endmodule

// File: tb/tb_captura_jogada.sv
// Scoreboard bench for captura_jogada with DEBOUNCE_N=4; adapts to CAPTURA_VALIDA_EN.
module tb_captura_jogada;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [5:0]  casa = '0;
   logic        confirma = 1'b0, cancela = 1'b0, zeraR = 1'b0;
   logic [11:0] jogada;
   logic        temJogada, erroJogada;
   logic [3:0]  db_estado;

   typedef struct packed { logic err; logic [11:0] jog; } ev_t;
   ev_t exp_q[$];
   ev_t obs_q[$];
   int  tests = 0, fails = 0;
   int  erro_long = 0;
   logic tem_prev = 1'b0, erro_prev = 1'b0;

   captura_jogada #(.DEBOUNCE_N(4)) dut (
      .clock(clock), .reset(reset), .casa(casa), .confirma(confirma),
      .cancela(cancela), .zeraR(zeraR), .jogada(jogada),
      .temJogada(temJogada), .erroJogada(erroJogada), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   // Monitor: record every error pulse and every temJogada rise as an observed event.
   always @(negedge clock) begin
      if (erroJogada) obs_q.push_back({1'b1, jogada});
      if (temJogada && !tem_prev) obs_q.push_back({1'b0, jogada});
      if (erroJogada && erro_prev) erro_long++;
      tem_prev  = temJogada;
      erro_prev = erroJogada;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic press(input logic c, input logic k, input int hold);
      confirma = c; cancela = k;
      tick(hold);
      confirma = 0; cancela = 0;
      tick(8);
   endtask

   task automatic pulse_zera();
      zeraR = 1;
      tick(1);
      zeraR = 0;
   endtask

   task automatic test_reset();
      reset = 0;
      tick(2);
      tests++; if (jogada !== 12'h000) begin fails++; $display("FAIL reset_jogada: got %h want 000", jogada); end
      tests++; if (temJogada !== 1'b0) begin fails++; $display("FAIL reset_tem: got %b want 0", temJogada); end
      tests++; if (erroJogada !== 1'b0) begin fails++; $display("FAIL reset_erro: got %b want 0", erroJogada); end
      tests++; if (db_estado !== 4'h0) begin fails++; $display("FAIL reset_estado: got %h want 0", db_estado); end
      reset = 1;
      tick(10);
   endtask

   task automatic test_basic();
      ev_t e, o;
      casa = 6'h0C;
      press(1, 0, 10);
      tests++; if (db_estado !== 4'h2) begin fails++; $display("FAIL basic_origem_state: got %h want 2", db_estado); end
      casa = 6'h1C;
      exp_q.push_back({1'b0, 12'h31C});
      press(1, 0, 10);
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL basic_evt: no output, want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL basic_evt: got %h want %h", o, e); end end
      tests++; if (temJogada !== 1'b1 || db_estado !== 4'h6) begin fails++; $display("FAIL basic_pronta: tem %b st %h want 1/6", temJogada, db_estado); end
      pulse_zera();
      tests++; if (temJogada !== 1'b0 || db_estado !== 4'h0) begin fails++; $display("FAIL basic_zera: tem %b st %h want 0/0", temJogada, db_estado); end
      tests++; if (jogada !== 12'h31C) begin fails++; $display("FAIL basic_hold: got %h want 31C", jogada); end
      tick(2);
   endtask

   task automatic test_glitch();
      casa = 6'h01;
      press(1, 0, 3);
      tests++; if (db_estado !== 4'h0 || obs_q.size() != 0) begin fails++; $display("FAIL glitch: st %h obs %0d want 0/0", db_estado, obs_q.size()); end
      press(1, 0, 6);
      tests++; if (db_estado !== 4'h2) begin fails++; $display("FAIL glitch_event: st %h want 2", db_estado); end
      press(0, 1, 6);
      tests++; if (db_estado !== 4'h0 || erro_long != 0 || obs_q.size() != 0) begin fails++; $display("FAIL glitch_cancel: st %h obs %0d want 0/0", db_estado, obs_q.size()); end
   endtask

   task automatic test_reject();
      ev_t e, o;
      casa = 6'h15;
      press(1, 0, 10);
`ifdef CAPTURA_VALIDA_EN
      exp_q.push_back({1'b1, 12'h555});
`else
      exp_q.push_back({1'b0, 12'h555});
`endif
      press(1, 0, 10);
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL reject_evt: no output, want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL reject_evt: got %h want %h", o, e); end end
`ifdef CAPTURA_VALIDA_EN
      tests++; if (temJogada !== 1'b0 || db_estado !== 4'h0 || erro_long != 0) begin fails++; $display("FAIL reject_state: tem %b st %h long %0d want 0/0/0", temJogada, db_estado, erro_long); end
`else
      tests++; if (temJogada !== 1'b1 || db_estado !== 4'h6) begin fails++; $display("FAIL accept_state: tem %b st %h want 1/6", temJogada, db_estado); end
      pulse_zera();
`endif
      tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL reject_extra: %0d extra events", obs_q.size()); end
   endtask

   task automatic test_simul();
      ev_t e, o;
      casa = 6'h0C;
      press(1, 0, 10);
      press(1, 1, 10);
      tests++; if (db_estado !== 4'h0 || obs_q.size() != 0) begin fails++; $display("FAIL simul: st %h obs %0d want 0/0", db_estado, obs_q.size()); end
      casa = 6'h01;
      press(1, 0, 10);
      casa = 6'h02;
      exp_q.push_back({1'b0, 12'h042});
      press(1, 0, 10);
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL simul_move: no output, want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL simul_move: got %h want %h", o, e); end end
      casa = 6'h3F;
      press(1, 0, 10);
      press(0, 1, 10);
      tests++; if (jogada !== 12'h042 || db_estado !== 4'h6 || temJogada !== 1'b1) begin fails++; $display("FAIL pronta_ignore: jog %h st %h want 042/6", jogada, db_estado); end
      pulse_zera();
      tick(2);
   endtask

   task automatic test_reset_pronta();
      ev_t e, o;
      casa = 6'h07;
      press(1, 0, 10);
      casa = 6'h38;
      exp_q.push_back({1'b0, 12'h1F8});
      press(1, 0, 10);
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL rst_move: no output, want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL rst_move: got %h want %h", o, e); end end
      confirma = 1;
      reset = 0;
      #1;
      tests++; if (jogada !== 12'h000 || temJogada !== 1'b0 || erroJogada !== 1'b0 || db_estado !== 4'h0) begin
         fails++; $display("FAIL rst_async: jog %h tem %b erro %b st %h want 000/0/0/0", jogada, temJogada, erroJogada, db_estado); end
      tick(3);
      reset = 1;
      tick(20);
      tests++; if (db_estado !== 4'h0) begin fails++; $display("FAIL rst_held: st %h want 0", db_estado); end
      confirma = 0;
      tick(10);
      tests++; if (db_estado !== 4'h0) begin fails++; $display("FAIL rst_release: st %h want 0", db_estado); end
      press(1, 0, 10);
      tests++; if (db_estado !== 4'h2) begin fails++; $display("FAIL rst_repress: st %h want 2", db_estado); end
      press(0, 1, 10);
      tests++; if (db_estado !== 4'h0 || obs_q.size() != 0) begin fails++; $display("FAIL rst_end: st %h obs %0d want 0/0", db_estado, obs_q.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_reject();
      test_simul();
      test_reset_pronta();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
